// File: rtl/api_rx_parser_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// api_rx_parser_pkg : block geometry, tag constants and FSM encoding
// Rev 1.0
// ---------------------------------------------------------------------------
package api_rx_parser_pkg;

  localparam int RX_BLOCK_LEN = 11;
  localparam int NONCE_IDX    = 2;
  localparam int JOB_IDX      = 0;
  localparam int MARKER_IDX   = 9;
  localparam int LAST_IDX     = RX_BLOCK_LEN - 1;

  localparam logic [31:0] MARKER   = 32'hbeafbeaf;
  localparam logic [7:0]  TAG_BYTE = 8'h12;

  localparam int IDX_W = $clog2(RX_BLOCK_LEN + 1);
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CHECK = 2'd2,
    OUT   = 2'd3
  } state_t;

  function automatic idx_t to_idx(input int i);
    return idx_t'(i);
  endfunction

endpackage
`default_nettype wire

// File: rtl/api_rx_parser_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// api_rx_parser_if : valid/ready nonce record port toward the CPU result path
// Rev 1.0
// ---------------------------------------------------------------------------
interface api_rx_parser_if;
  logic        valid;
  logic        ready;
  logic [31:0] job;
  logic [31:0] nonce;
  logic [3:0]  miner_id;
  logic [15:0] status;

  modport master (output valid, job, nonce, miner_id, status, input ready);
  modport slave  (input valid, job, nonce, miner_id, status, output ready);
endinterface
`default_nettype wire

// File: rtl/api_rx_parser_sat_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// api_rx_parser_sat_cnt : 16-bit saturating counter, clear beats increment
// Rev 1.0
// ---------------------------------------------------------------------------
module api_rx_parser_sat_cnt (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        i_inc,
  input  wire logic        i_clr,
  output logic      [15:0] o_cnt
);

  logic [15:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= 16'd0;
    else if (i_clr)
      r_cnt <= 16'd0;
    else if (i_inc && (r_cnt != 16'hffff))
      r_cnt <= r_cnt + 16'd1;
  end

  assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/api_rx_parser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// api_rx_parser : drains RX FIFO blocks, validates, de-duplicates nonces
// Rev 1.0
// ---------------------------------------------------------------------------
module api_rx_parser
  import api_rx_parser_pkg::*;
(
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          rx_fifo_empty,
  output logic               rx_fifo_rd_en,
  input  wire logic [31:0]   rx_fifo_dout,
  input  wire logic          flush,
  api_rx_parser_if.master    res,
  output logic      [15:0]   blk_cnt,
  output logic      [15:0]   nonce_cnt,
  output logic      [15:0]   dup_cnt,
  output logic      [15:0]   err_cnt,
  input  wire logic          clr_cnt
);

  state_t      r_state, w_state_nxt;
  idx_t        r_issued, r_rcvd, w_rcvd_nxt;
  logic        r_rd_pend;
  logic        w_rd_en, w_cap;

  // Only the words the checks and the record need are kept
  logic [31:0] r_job_w, r_nonce_w, r_marker_w;
  logic [15:0] r_tail_status;
  logic [7:0]  r_tail_tag;
  logic [3:0]  r_tail_id;

  logic        r_res_valid;
  logic [31:0] r_res_job, r_res_nonce;
  logic [3:0]  r_res_miner_id;
  logic [15:0] r_res_status;
  logic [35:0] r_last;
  logic        r_last_vld;

  logic        w_tag_ok, w_mark_ok, w_dup;
  logic        w_blk_inc, w_err_inc, w_dup_inc, w_nonce_inc, w_hit;

  assign w_rd_en    = (r_state == READ) && !rx_fifo_empty && (r_issued < to_idx(RX_BLOCK_LEN));
  assign w_cap      = r_rd_pend;
  assign w_rcvd_nxt = r_rcvd + idx_t'(w_cap);
  assign w_tag_ok   = (r_tail_tag == TAG_BYTE);
  assign w_mark_ok  = (r_marker_w == MARKER);
  assign w_dup      = r_last_vld && (r_last == {r_nonce_w, r_tail_id});

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_blk_inc   = 1'b0;
    w_err_inc   = 1'b0;
    w_dup_inc   = 1'b0;
    w_nonce_inc = 1'b0;
    w_hit       = 1'b0;
    case (r_state)
      IDLE: if (!flush && !rx_fifo_empty) w_state_nxt = READ;
      READ: begin
        if (flush)
          w_state_nxt = IDLE;
        else if (w_rcvd_nxt == to_idx(RX_BLOCK_LEN))
          w_state_nxt = CHECK;
      end
      CHECK: begin
        w_state_nxt = IDLE;
        if (!flush) begin
          w_blk_inc = 1'b1;
          if (!w_tag_ok) begin
            w_err_inc = 1'b1;
          end else if (w_mark_ok) begin
            if (w_dup) begin
              w_dup_inc = 1'b1;
            end else begin
              w_hit       = 1'b1;
              w_state_nxt = OUT;
            end
          end
        end
      end
      OUT: begin
        // flush is deliberately ignored here so the handshake always completes
        if (r_res_valid && res.ready) begin
          w_nonce_inc = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issued       <= '0;
      r_rcvd         <= '0;
      r_rd_pend      <= 1'b0;
      r_job_w        <= 32'd0;
      r_nonce_w      <= 32'd0;
      r_marker_w     <= 32'd0;
      r_tail_status  <= 16'd0;
      r_tail_tag     <= 8'd0;
      r_tail_id      <= 4'd0;
      r_res_valid    <= 1'b0;
      r_res_job      <= 32'd0;
      r_res_nonce    <= 32'd0;
      r_res_miner_id <= 4'd0;
      r_res_status   <= 16'd0;
      r_last         <= 36'd0;
      r_last_vld     <= 1'b0;
    end else begin
      // A return landing on the flush cycle or after it is dropped
      r_rd_pend <= w_rd_en && !flush;
      if ((r_state == IDLE) || (flush && (r_state != OUT))) begin
        r_issued <= '0;
        r_rcvd   <= '0;
      end else begin
        if (w_rd_en)
          r_issued <= r_issued + to_idx(1);
        if (w_cap) begin
          r_rcvd <= w_rcvd_nxt;
          if (r_rcvd == to_idx(JOB_IDX))    r_job_w    <= rx_fifo_dout;
          if (r_rcvd == to_idx(NONCE_IDX))  r_nonce_w  <= rx_fifo_dout;
          if (r_rcvd == to_idx(MARKER_IDX)) r_marker_w <= rx_fifo_dout;
          if (r_rcvd == to_idx(LAST_IDX)) begin
            r_tail_status <= rx_fifo_dout[31:16];
            r_tail_tag    <= rx_fifo_dout[15:8];
            r_tail_id     <= rx_fifo_dout[3:0];
          end
        end
      end
      if (w_hit) begin
        r_res_valid    <= 1'b1;
        r_res_job      <= r_job_w;
        r_res_nonce    <= r_nonce_w;
        r_res_miner_id <= r_tail_id;
        r_res_status   <= r_tail_status;
      end else if (w_nonce_inc) begin
        r_res_valid <= 1'b0;
        r_last      <= {r_res_nonce, r_res_miner_id};
        r_last_vld  <= 1'b1;
      end
    end
  end

  assign rx_fifo_rd_en = w_rd_en;
  assign res.valid     = r_res_valid;
  assign res.job       = r_res_job;
  assign res.nonce     = r_res_nonce;
  assign res.miner_id  = r_res_miner_id;
  assign res.status    = r_res_status;

  api_rx_parser_sat_cnt u_blk_cnt (
    .clk(clk), .rst(rst), .i_inc(w_blk_inc), .i_clr(clr_cnt), .o_cnt(blk_cnt));
  api_rx_parser_sat_cnt u_nonce_cnt (
    .clk(clk), .rst(rst), .i_inc(w_nonce_inc), .i_clr(clr_cnt), .o_cnt(nonce_cnt));
  api_rx_parser_sat_cnt u_dup_cnt (
    .clk(clk), .rst(rst), .i_inc(w_dup_inc), .i_clr(clr_cnt), .o_cnt(dup_cnt));
  api_rx_parser_sat_cnt u_err_cnt (
    .clk(clk), .rst(rst), .i_inc(w_err_inc), .i_clr(clr_cnt), .o_cnt(err_cnt));

endmodule
`default_nettype wire

// File: tb/tb_api_rx_parser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_api_rx_parser : directed blocks with a record scoreboard and counter checks
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_api_rx_parser;
  import api_rx_parser_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        rx_fifo_rd_en;
  logic        rx_fifo_empty;
  logic [31:0] rx_fifo_dout = 32'd0;
  logic [15:0] blk_cnt, nonce_cnt, dup_cnt, err_cnt;

  always #5 clk = ~clk;

  api_rx_parser_if res ();

  api_rx_parser dut (
    .clk(clk), .rst(rst),
    .rx_fifo_empty(rx_fifo_empty), .rx_fifo_rd_en(rx_fifo_rd_en), .rx_fifo_dout(rx_fifo_dout),
    .flush(flush), .res(res),
    .blk_cnt(blk_cnt), .nonce_cnt(nonce_cnt), .dup_cnt(dup_cnt), .err_cnt(err_cnt),
    .clr_cnt(clr_cnt));

  // FIFO model: read data appears one clock after rd_en
  logic [31:0] fmem [256];
  logic [7:0]  wp = 8'd0;
  logic [7:0]  rp = 8'd0;
  assign rx_fifo_empty = (wp == rp);
  always @(posedge clk) begin
    if (rx_fifo_rd_en) begin
      rx_fifo_dout <= fmem[rp];
      rp           <= rp + 8'd1;
    end
  end

  typedef struct packed {
    logic [31:0] job;
    logic [31:0] nonce;
    logic [3:0]  id;
    logic [15:0] st;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  rec_t cur;
  rec_t held;
  bit   held_v = 1'b0;
  assign cur = {res.job, res.nonce, res.miner_id, res.status};

  always @(negedge clk) begin
    if (held_v) begin
      checks++;
      if (!res.valid || (cur != held)) begin
        errors++;
        $display("FAIL rec_stable: actual valid=%0b rec=%h required valid=1 rec=%h", res.valid, cur, held);
      end
    end
    held_v = 1'b0;
    if (res.valid) begin
      if (res.ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rec_unexpected: actual rec=%h required no record", cur);
        end else begin
          rec_t e;
          e = exp_q.pop_front();
          if (cur != e) begin
            errors++;
            $display("FAIL rec_fields: actual %h required %h", cur, e);
          end
        end
      end else begin
        held   = cur;
        held_v = 1'b1;
      end
    end
  end

  logic [31:0] bw [RX_BLOCK_LEN];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build(input logic [31:0] job, input logic [31:0] nonce,
                       input logic [31:0] mark, input logic [31:0] last);
    for (int i = 0; i < RX_BLOCK_LEN; i++) bw[i] = 32'h0a000000 + 32'(i);
    bw[JOB_IDX]    = job;
    bw[NONCE_IDX]  = nonce;
    bw[MARKER_IDX] = mark;
    bw[LAST_IDX]   = last;
  endtask

  task automatic push(input int from, input int upto);
    for (int i = from; i < upto; i++) begin
      fmem[wp] = bw[i];
      wp       = wp + 8'd1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h", nm, act, req);
    end
  endtask

  task automatic chk_cnts(input logic [15:0] b, input logic [15:0] n,
                          input logic [15:0] d, input logic [15:0] e);
    chk("blk_cnt", {16'd0, blk_cnt}, {16'd0, b});
    chk("nonce_cnt", {16'd0, nonce_cnt}, {16'd0, n});
    chk("dup_cnt", {16'd0, dup_cnt}, {16'd0, d});
    chk("err_cnt", {16'd0, err_cnt}, {16'd0, e});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (2) tick();
    while (!((dut.r_state == IDLE) && (wp == rp) && !res.valid) && (n < 300)) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: actual state=%0d required IDLE", dut.r_state);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual time %0t required finish earlier", $time);
    $fatal(1);
  end

  initial begin
    int rd, run, maxrun, n;
    res.ready = 1'b1;
    repeat (3) tick();
    chk_cnts(16'd0, 16'd0, 16'd0, 16'd0);
    chk("rst_valid", {31'd0, res.valid}, 32'd0);
    chk("rst_rd_en", {31'd0, rx_fifo_rd_en}, 32'd0);
    rst = 1'b0;
    tick();

    // Single good block; rd_en must run 11 back-to-back cycles
    build(32'h11111111, 32'hdeadbeef, MARKER, 32'h0003_1205);
    exp_q.push_back({32'h11111111, 32'hdeadbeef, 4'h5, 16'h0003});
    push(0, RX_BLOCK_LEN);
    rd = 0; run = 0; maxrun = 0;
    repeat (40) begin
      tick();
      if (rx_fifo_rd_en) begin
        rd++;
        run++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
    end
    chk("rd_en_count", 32'(rd), 32'd11);
    chk("rd_en_run", 32'(maxrun), 32'd11);
    wait_idle();
    chk_cnts(16'd1, 16'd1, 16'd0, 16'd0);

    // Duplicate, then same nonce from another miner
    push(0, RX_BLOCK_LEN);
    wait_idle();
    chk_cnts(16'd2, 16'd1, 16'd1, 16'd0);
    build(32'h11111111, 32'hdeadbeef, MARKER, 32'h0003_1206);
    exp_q.push_back({32'h11111111, 32'hdeadbeef, 4'h6, 16'h0003});
    push(0, RX_BLOCK_LEN);
    wait_idle();
    chk_cnts(16'd3, 16'd2, 16'd1, 16'd0);

    // Bad tag, then good tag without marker
    build(32'h33333333, 32'h0000cafe, MARKER, 32'h0003_3405);
    push(0, RX_BLOCK_LEN);
    wait_idle();
    chk_cnts(16'd4, 16'd2, 16'd1, 16'd1);
    build(32'h33333333, 32'h0000f00d, 32'h0, 32'h0001_1201);
    push(0, RX_BLOCK_LEN);
    wait_idle();
    chk_cnts(16'd5, 16'd2, 16'd1, 16'd1);

    // FIFO stall mid-block plus consumer back-pressure
    res.ready = 1'b0;
    build(32'h22222222, 32'h12345678, MARKER, 32'h00aa_1207);
    exp_q.push_back({32'h22222222, 32'h12345678, 4'h7, 16'h00aa});
    push(0, 5);
    repeat (7) tick();
    push(5, RX_BLOCK_LEN);
    n = 0;
    while (!res.valid && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: actual valid=0 required 1");
    end
    repeat (5) tick();
    res.ready = 1'b1;
    wait_idle();
    chk_cnts(16'd6, 16'd3, 16'd1, 16'd1);

    // Partial block aborted by flush, then a full good block
    build(32'h44444444, 32'hbad0bad0, MARKER, 32'h0001_1208);
    push(0, 6);
    repeat (12) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    build(32'h55555555, 32'h0badf00d, MARKER, 32'h0055_1209);
    exp_q.push_back({32'h55555555, 32'h0badf00d, 4'h9, 16'h0055});
    push(0, RX_BLOCK_LEN);
    wait_idle();
    chk_cnts(16'd7, 16'd4, 16'd1, 16'd1);

    // Saturation of blk_cnt
    force dut.u_blk_cnt.r_cnt = 16'hffff;
    tick();
    release dut.u_blk_cnt.r_cnt;
    build(32'h66666666, 32'h00000777, 32'h0, 32'h0000_1201);
    push(0, RX_BLOCK_LEN);
    wait_idle();
    chk_cnts(16'hffff, 16'd4, 16'd1, 16'd1);

    // Clear coinciding with an err_cnt increment
    build(32'h77777777, 32'h00000888, MARKER, 32'h0000_3301);
    push(0, RX_BLOCK_LEN);
    n = 0;
    while ((dut.r_state != CHECK) && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL check_timeout: actual state=%0d required CHECK", dut.r_state);
    end
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk_cnts(16'd0, 16'd0, 16'd0, 16'd0);
    wait_idle();

    // Duplicate filter survives clr_cnt
    build(32'h55555555, 32'h0badf00d, MARKER, 32'h0055_1209);
    push(0, RX_BLOCK_LEN);
    wait_idle();
    chk_cnts(16'd1, 16'd0, 16'd1, 16'd0);

    chk("exp_q_left", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
